// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: main control for the 5-stage core.
// Decodes the IF/ID instruction into the control bundle, registers it into
// ID/EX, detects load-use hazards, squashes on taken branches and runs the
// halt-drain state machine.
module pipe_ctrl_unit #(
  parameter int INSTR_W    = 16,
  parameter int REG_AW     = 4,
  parameter int HALT_DRAIN = 3,
  parameter int CTL_W      = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               ex_br_taken,
  output logic [CTL_W-1:0]   ex_ctl,
  output logic               ex_valid,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic               stall,
  output logic               fetch_en,
  output logic               halted
);

  // The bundle layout is fixed; any other width is a configuration mistake.
  if (CTL_W != 19) begin : g_bad_ctl_w
    $error("pipe_ctrl_unit: CTL_W must be 19");
  end
  if ((HALT_DRAIN < 1) || (HALT_DRAIN > 15)) begin : g_bad_drain
    $error("pipe_ctrl_unit: HALT_DRAIN must be in 1..15");
  end

  localparam int RD_MSB = INSTR_W - 5;
  localparam int RS_MSB = RD_MSB - REG_AW;
  localparam int RT_MSB = RS_MSB - REG_AW;
  localparam int CTL_MEMREAD = 4;
  localparam logic [3:0] DRAIN_LOAD = 4'(HALT_DRAIN);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [CTL_W-1:0]    ex_ctl_q, ex_ctl_d;
  logic                ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0]   ex_rd_q, ex_rd_d, ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic                fetch_en_q, fetch_en_d;
  logic                halted_q, halted_d;

  logic [3:0]          opc_s;
  logic [REG_AW-1:0]   id_rd_s, id_rs_s, id_rt_s;
  logic                halt_s, alusrc_s, brr_s, br_s, m2r_s, mw_s, mr_s, rw_s, src2_s;
  logic [1:0]          clr_s, dst_s;
  logic [2:0]          sf_s, aluop_s;
  logic                use_rs_s, use_rt_s, use_rd_s;
  logic [CTL_W-1:0]    dec_ctl_s;
  logic                hit_s, stall_s;

  assign opc_s   = id_instr[INSTR_W-1 -: 4];
  assign id_rd_s = id_instr[RD_MSB -: REG_AW];
  assign id_rs_s = id_instr[RS_MSB -: REG_AW];
  assign id_rt_s = id_instr[RT_MSB -: REG_AW];

  // Opcode decode into control fields and source-register usage.
  always_comb begin
    halt_s = 1'b0; clr_s = 2'b00; sf_s = 3'b000; aluop_s = 3'b000;
    alusrc_s = 1'b0; brr_s = 1'b0; br_s = 1'b0; m2r_s = 1'b0;
    mw_s = 1'b0; mr_s = 1'b0; rw_s = 1'b0; src2_s = 1'b0; dst_s = 2'b00;
    use_rs_s = 1'b0; use_rt_s = 1'b0; use_rd_s = 1'b0;
    case (opc_s)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        dst_s = 2'b01; rw_s = 1'b1; aluop_s = opc_s[2:0];
        use_rs_s = 1'b1; use_rt_s = 1'b1;
        if (opc_s[1] == 1'b0) begin
          sf_s = 3'b111;
        end else if (opc_s[0] == 1'b1) begin
          sf_s = 3'b100;
        end else begin
          sf_s = 3'b000;
        end
      end
      4'b0100, 4'b0101, 4'b0110: begin
        dst_s = 2'b01; rw_s = 1'b1; alusrc_s = 1'b1; aluop_s = opc_s[2:0];
        sf_s = 3'b100; clr_s = 2'b01; use_rs_s = 1'b1;
      end
      4'b0111: begin
        dst_s = 2'b01; rw_s = 1'b1; aluop_s = 3'b111;
        use_rs_s = 1'b1; use_rt_s = 1'b1;
      end
      4'b1000: begin
        dst_s = 2'b01; rw_s = 1'b1; mr_s = 1'b1; m2r_s = 1'b1; alusrc_s = 1'b1;
        clr_s = 2'b01; use_rs_s = 1'b1;
      end
      4'b1001: begin
        dst_s = 2'b01; src2_s = 1'b1; mw_s = 1'b1; alusrc_s = 1'b1;
        clr_s = 2'b01; use_rs_s = 1'b1; use_rd_s = 1'b1;
      end
      4'b1010: begin
        dst_s = 2'b11; src2_s = 1'b1; rw_s = 1'b1; alusrc_s = 1'b1;
        clr_s = 2'b11; use_rd_s = 1'b1;
      end
      4'b1011: begin
        dst_s = 2'b10; src2_s = 1'b1; rw_s = 1'b1; alusrc_s = 1'b1;
        clr_s = 2'b11; use_rd_s = 1'b1;
      end
      4'b1100: begin
        br_s = 1'b1; clr_s = 2'b11;
      end
      4'b1101: begin
        br_s = 1'b1; brr_s = 1'b1; clr_s = 2'b01; use_rs_s = 1'b1;
      end
      4'b1110: begin
        dst_s = 2'b00; rw_s = 1'b1; clr_s = 2'b11;
      end
      4'b1111: begin
        halt_s = 1'b1; clr_s = 2'b11;
      end
      default: begin
        halt_s = 1'b0;
      end
    endcase
    dec_ctl_s = {halt_s, clr_s, sf_s, aluop_s, alusrc_s, brr_s, br_s,
                 m2r_s, mw_s, mr_s, rw_s, src2_s, dst_s};
  end

  // Load-use hazard: a load in EX writing a register the ID instruction reads.
  always_comb begin
    hit_s = (use_rs_s && (ex_rd_q == id_rs_s)) ||
            (use_rt_s && (ex_rd_q == id_rt_s)) ||
            (use_rd_s && (ex_rd_q == id_rd_s));
    stall_s = id_valid && ex_valid_q && ex_ctl_q[CTL_MEMREAD] &&
              (ex_rd_q != {REG_AW{1'b0}}) && hit_s && !ex_br_taken &&
              (state_q == ST_RUN);
  end

  // ID/EX next value and halt-drain FSM (flush > stall > issue).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fetch_en_d = fetch_en_q;
    halted_d   = halted_q;
    ex_ctl_d   = {CTL_W{1'b0}};
    ex_valid_d = 1'b0;
    ex_rd_d    = {REG_AW{1'b0}};
    ex_rs_d    = {REG_AW{1'b0}};
    ex_rt_d    = {REG_AW{1'b0}};
    case (state_q)
      ST_RUN: begin
        fetch_en_d = 1'b1;
        if (ex_br_taken) begin
          ex_valid_d = 1'b0;
        end else if (stall_s) begin
          ex_valid_d = 1'b0;
        end else begin
          ex_ctl_d   = dec_ctl_s;
          ex_valid_d = id_valid;
          ex_rd_d    = id_rd_s;
          ex_rs_d    = id_rs_s;
          ex_rt_d    = id_rt_s;
          if (id_valid && halt_s) begin
            state_d    = ST_DRAIN;
            cnt_d      = DRAIN_LOAD;
            fetch_en_d = 1'b0;
          end else begin
            cnt_d = 4'd0;
          end
        end
      end
      ST_DRAIN: begin
        fetch_en_d = 1'b0;
        if (cnt_q <= 4'd1) begin
          state_d  = ST_HALTED;
          cnt_d    = 4'd0;
          halted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HALTED: begin
        fetch_en_d = 1'b0;
        halted_d   = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        cnt_d      = 4'd0;
        fetch_en_d = 1'b1;
        halted_d   = 1'b0;
      end
    endcase
  end

  // Pipeline register and FSM state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= 4'd0;
      fetch_en_q <= 1'b1;
      halted_q   <= 1'b0;
      ex_ctl_q   <= {CTL_W{1'b0}};
      ex_valid_q <= 1'b0;
      ex_rd_q    <= {REG_AW{1'b0}};
      ex_rs_q    <= {REG_AW{1'b0}};
      ex_rt_q    <= {REG_AW{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fetch_en_q <= fetch_en_d;
      halted_q   <= halted_d;
      ex_ctl_q   <= ex_ctl_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
    end
  end

  assign ex_ctl   = ex_ctl_q;
  assign ex_valid = ex_valid_q;
  assign ex_rd    = ex_rd_q;
  assign ex_rs    = ex_rs_q;
  assign ex_rt    = ex_rt_q;
  assign stall    = stall_s;
  assign fetch_en = fetch_en_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit: scoreboard of expected ID/EX contents,
// one task per scenario.
module tb_pipe_ctrl_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [15:0] id_instr;
  logic        ex_br_taken;
  logic [18:0] ex_ctl;
  logic        ex_valid;
  logic [3:0]  ex_rd, ex_rs, ex_rt;
  logic        stall, fetch_en, halted;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [18:0] ctl;
    logic        valid;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl_unit #(.INSTR_W(16), .REG_AW(4), .HALT_DRAIN(3), .CTL_W(19)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .ex_br_taken(ex_br_taken), .ex_ctl(ex_ctl), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt), .stall(stall),
    .fetch_en(fetch_en), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundle per opcode, hand-assembled from the decode table.
  function automatic logic [18:0] exp_ctl(input logic [3:0] opc);
    case (opc)
      4'h0: return 19'h0E009;  // ADD
      4'h1: return 19'h0E409;  // SUB
      4'h2: return 19'h00809;  // RED
      4'h3: return 19'h08C09;  // XOR
      4'h4: return 19'h19209;  // SLL
      4'h5: return 19'h19609;  // SRA
      4'h6: return 19'h19A09;  // ROR
      4'h7: return 19'h01C09;  // PADDSB
      4'h8: return 19'h10259;  // LW
      4'h9: return 19'h10225;  // SW
      4'hA: return 19'h3020F;  // LHB
      4'hB: return 19'h3020E;  // LLB
      4'hC: return 19'h30080;  // B
      4'hD: return 19'h10180;  // BR
      4'hE: return 19'h30008;  // PCS
      default: return 19'h70000;  // HALT
    endcase
  endfunction

  // Source fields read per opcode: {rs, rt, rd}.
  function automatic logic [2:0] uses_of(input logic [3:0] opc);
    if (opc <= 4'h3 || opc == 4'h7) return 3'b110;
    else if (opc <= 4'h6 || opc == 4'h8 || opc == 4'hD) return 3'b100;
    else if (opc == 4'h9) return 3'b101;
    else if (opc == 4'hA || opc == 4'hB) return 3'b001;
    else return 3'b000;
  endfunction

  // One cycle: drive at negedge, check stall, push expectation, check after edge.
  task automatic step(input logic v, input logic [15:0] ins, input logic br,
                      input logic e_stall, input logic e_bub, input logic e_fe,
                      input logic e_halt, input string tag);
    exp_t e;
    id_valid = v; id_instr = ins; ex_br_taken = br;
    #1;
    checks++;
    if (stall !== e_stall) begin
      failures++;
      $display("FAIL %s stall got=%0b exp=%0b", tag, stall, e_stall);
    end
    if (e_bub) e = '{19'h0, 1'b0, 4'h0, 4'h0, 4'h0};
    else e = '{exp_ctl(ins[15:12]), v, ins[11:8], ins[7:4], ins[3:0]};
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({ex_ctl, ex_valid, ex_rd, ex_rs, ex_rt} !== e) begin
      failures++;
      $display("FAIL %s idex got=%h/%0b/%0d/%0d/%0d exp=%h/%0b/%0d/%0d/%0d", tag,
               ex_ctl, ex_valid, ex_rd, ex_rs, ex_rt, e.ctl, e.valid, e.rd, e.rs, e.rt);
    end
    checks++;
    if ({fetch_en, halted} !== {e_fe, e_halt}) begin
      failures++;
      $display("FAIL %s fetch_en/halted got=%0b/%0b exp=%0b/%0b", tag,
               fetch_en, halted, e_fe, e_halt);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; id_valid = 1'b0; id_instr = 16'h0000; ex_br_taken = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ex_ctl, ex_valid, ex_rd, ex_rs, ex_rt, stall, fetch_en, halted} !==
        {19'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset got ctl=%h v=%0b rd=%0d rs=%0d rt=%0d st=%0b fe=%0b h=%0b exp all 0 except fe=1",
               ex_ctl, ex_valid, ex_rd, ex_rs, ex_rt, stall, fetch_en, halted);
    end
    step(1'b1, 16'h0312, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "add_r3");
  endtask

  task automatic test_decode();
    logic       prev_lw;
    logic [3:0] prev_rd, rd, rs, rt;
    logic [2:0] u;
    logic       haz;
    logic [15:0] ins;
    prev_lw = 1'b0; prev_rd = 4'h0;
    for (int p = 0; p < 3; p++) begin
      for (int o = 0; o < 15; o++) begin
        rd = 4'($urandom_range(0, 15));
        rs = (p == 0) ? prev_rd : 4'($urandom_range(0, 15));
        rt = (p == 1) ? prev_rd : 4'($urandom_range(0, 15));
        ins = {o[3:0], rd, rs, rt};
        u = uses_of(o[3:0]);
        haz = prev_lw && (prev_rd != 4'h0) &&
              ((u[2] && prev_rd == rs) || (u[1] && prev_rd == rt) || (u[0] && prev_rd == rd));
        if (haz) step(1'b1, ins, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "decode_stall");
        step(1'b1, ins, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "decode");
        prev_lw = (o == 8);
        prev_rd = rd;
      end
    end
  endtask

  task automatic test_load_use();
    step(1'b1, 16'h8510, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lw_r5");
    step(1'b1, 16'h0652, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "lu_stall");
    step(1'b1, 16'h0652, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lu_issue");
    step(1'b1, 16'h8510, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lw_r5b");
    step(1'b1, 16'h9512, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "sw_rd_stall");
    step(1'b1, 16'h9512, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "sw_issue");
  endtask

  task automatic test_no_hazard();
    step(1'b1, 16'h8010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lw_r0");
    step(1'b1, 16'h0602, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "add_after_lw_r0");
    step(1'b1, 16'h8510, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lw_r5c");
    step(1'b1, 16'hC555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b_after_lw");
  endtask

  task automatic test_flush();
    step(1'b1, 16'h8510, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lw_r5d");
    step(1'b1, 16'h0652, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "flush_hazard");
    step(1'b1, 16'h8510, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lw_r5e");
    step(1'b1, 16'hF000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "flush_halt");
    step(1'b1, 16'h0312, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "run_after_flush");
  endtask

  task automatic test_halt();
    step(1'b1, 16'h0312, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pre_halt");
    step(1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "halt_issue");
    step(1'b1, 16'h0312, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "drain1");
    step(1'b1, 16'h8510, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "drain2");
    step(1'b1, 16'h0512, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "drain3");
    for (int i = 0; i < 20; i++)
      step(1'b1, 16'h0312, i[0], 1'b0, 1'b1, 1'b0, 1'b1, "halted_hold");
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "halt_issue2");
    step(1'b1, 16'h0312, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "drain_cnt2");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_ctl, ex_valid, ex_rd, fetch_en, halted} !== {19'h0, 1'b0, 4'h0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got ctl=%h v=%0b rd=%0d fe=%0b h=%0b exp 0/0/0/1/0",
               ex_ctl, ex_valid, ex_rd, fetch_en, halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h0312, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "add_after_reset");
    for (int i = 0; i < 5; i++)
      step(1'b1, 16'h0745, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "run_no_residual");
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_instr = 16'h0000; ex_br_taken = 1'b0;
    @(negedge clk);
    test_reset();
    test_decode();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_halt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Next-generation main control for the 5-stage core.
- Decodes the 16-bit instruction held in IF/ID into the full control bundle and registers it into ID/EX.
- Detects load-use hazards and generates stall and bubble.
- Squashes wrong-path instructions on a taken branch.
- Runs a halt-drain state machine that stops fetch and raises a sticky halted flag once the pipeline has emptied.

Parameters:
- INSTR_W, 16: instruction width. Opcode = instr[INSTR_W-1 -: 4]; rd/rs/rt fields are the next three REG_AW-bit fields downward.
- REG_AW, 4: register address width. Register 0 is hardwired zero.
- HALT_DRAIN, 3: cycles to wait in DRAIN after HALT enters EX (range 1..15).
- CTL_W, 19: control bundle width. Fixed; any other value is an elaboration error.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  INSTR_W  instruction in IF/ID.
- ex_br_taken  in  1  branch in EX resolved taken; flush request.
- ex_ctl  out  CTL_W  registered bundle, bits {Halt, ClearRST[1:0], SetFlags[2:0], ALUOp[2:0], ALUSrc, BranchReg, Branch, MemToReg, MemWrite, MemRead, RegWrite, RegSrc2Ctl, RegDst[1:0]}, MSB first.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_rd / ex_rs / ex_rt  out  REG_AW each  registered register fields.
- stall  out  1  combinational; hold PC and IF/ID.
- fetch_en  out  1  registered; 0 stops PC update in DRAIN/HALTED.
- halted  out  1  registered; sticky until reset.

Behaviour:
- Reset (async assert, sync release): ex_ctl=0, ex_valid=0, ex_rd/rs/rt=0, fetch_en=1, halted=0, state=RUN.
- Decode is combinational from the opcode. Every field is assigned for every opcode; there is no latch and no unassigned ClearRST.
  - 0000-0011 (ADD/SUB/RED/XOR): RegDst=01, RW=1, ALUSrc=0, ALUOp=opc[2:0], ClrRST=00. SetFlags: ADD/SUB 111, RED 000, XOR 100.
  - 0100-0110 (SLL/SRA/ROR): RegDst=01, RW=1, ALUSrc=1, ALUOp=opc[2:0], SetFlags=100, ClrRST=01.
  - 0111 PADDSB: RegDst=01, RW=1, ALUOp=111, SetFlags=000, ClrRST=00.
  - 1000 LW: RegDst=01, RW=1, MR=1, M2R=1, ALUSrc=1, ClrRST=01.
  - 1001 SW: RegDst=01, Src2=1, MW=1, ALUSrc=1, ClrRST=01.
  - 1010 LHB: RegDst=11, Src2=1, RW=1, ALUSrc=1, ClrRST=11.
  - 1011 LLB: RegDst=10, Src2=1, RW=1, ALUSrc=1, ClrRST=11.
  - 1100 B: Br=1, ClrRST=11.
  - 1101 BR: Br=1, BrR=1, ClrRST=01.
  - 1110 PCS: RegDst=00, RW=1, ClrRST=11.
  - 1111 HALT: Halt=1, ClrRST=11.
  - Every field not listed for an opcode is 0.
- Source usage for hazard detection:
  - ALU reg ops and PADDSB read rs and rt.
  - Shifts, LW and BR read rs.
  - SW reads rs and the rd field.
  - LHB/LLB read the rd field.
  - B, PCS and HALT read nothing.
- Load-use detection: stall = id_valid & ex_valid & ex_ctl.MemRead & (ex_rd != 0) & (ex_rd matches a used source) & ~ex_br_taken & (state==RUN).
- Stall cycle: ID/EX loads a bubble (ex_valid=0, ex_ctl=0), IF/ID is held, and the instruction issues on the next cycle. Stall lasts exactly 1 cycle per load.
- Flush (ex_br_taken=1): ID/EX loads a bubble and the ID instruction is discarded. A HALT in ID is cancelled and the state is unchanged. Flush overrides stall.
- Normal issue: ID/EX loads the decoded bundle and fields; ex_valid=id_valid.
- Priority: reset > flush > stall > issue.
- Halt FSM:
  - RUN to DRAIN when a HALT issues into EX (id_valid, no stall, no flush). fetch_en drops to 0 on that same edge and cnt loads HALT_DRAIN.
  - DRAIN: ID/EX loads bubbles, stall=0, ex_br_taken is ignored, cnt decrements each cycle. At cnt==1 the state goes to HALTED.
  - HALTED: halted=1 and fetch_en=0; ID/EX stays bubble. Only reset exits.
- Reset asserted in any state returns to RUN immediately (asynchronously), with no residual count.

Test Plan:
- ADD r3,r1,r2 (0x0312) valid, no hazard -> next edge: ex_ctl = SetFlags 111, RW=1, RegDst=01, ex_valid=1, ex_rd=3, stall=0.
- LW r5 in EX followed by ADD r6,r5,r2 in ID -> stall=1 for 1 cycle, ex_valid=0 that cycle; ADD issues on the next cycle with ex_rs=5.
- LW r0 in EX followed by ADD r6,r0,r2 in ID, and LW r5 followed by B -> stall=0 in both cases.
- ex_br_taken=1 together with a load-use hazard and HALT in ID -> stall=0, bubble issued, state stays RUN, fetch_en=1.
- HALT issued with HALT_DRAIN=3 -> fetch_en=0 on the issue edge; halted=1 exactly 3 cycles later; halted stays 1 for 20 further cycles.
- rst_n pulsed low mid-DRAIN (cnt=2), asynchronously -> outputs reset immediately; after release an ADD issues normally and halted=0.
